// File: rtl/sm_hazard_ctrl.sv
// Hazard and pipeline-control unit for the five-stage schoolMIPS pipeline:
// forwarding into E, RAW/load-use stall, branch flush, data-memory wait FSM with timeout, perf counters.
module sm_hazard_ctrl #(
  parameter int unsigned REG_W         = 5,
  parameter int unsigned FORWARD_EN    = 1,
  parameter int unsigned LOAD_STALL_EN = 1,
  parameter int unsigned MEM_TIMEOUT   = 15,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] instrRs_D,
  input  logic [REG_W-1:0] instrRt_D,
  input  logic [REG_W-1:0] instrRs_E,
  input  logic [REG_W-1:0] instrRt_E,
  input  logic [REG_W-1:0] writeReg_E,
  input  logic [REG_W-1:0] writeReg_M,
  input  logic [REG_W-1:0] writeReg_W,
  input  logic             cw_regWrite_E,
  input  logic             cw_regWrite_M,
  input  logic             cw_regWrite_W,
  input  logic             cw_memToReg_E,
  input  logic             cw_memToReg_M,
  input  logic             cw_memWrite_M,
  input  logic             cw_pcSrc_M,
  input  logic             dmAck,
  output logic             dmReq,
  output logic [1:0]       hz_forwardA_E,
  output logic [1:0]       hz_forwardB_E,
  output logic             hz_stall_F,
  output logic             hz_stall_D,
  output logic             hz_stall_E,
  output logic             hz_stall_M,
  output logic             hz_flush_n_D,
  output logic             hz_flush_n_E,
  output logic             hz_flush_n_M,
  output logic             hz_flush_n_W,
  output logic             hz_memErr,
  output logic [CNT_W-1:0] cnt_luStall,
  output logic [CNT_W-1:0] cnt_memWait,
  output logic [CNT_W-1:0] cnt_flush
);

  localparam logic [1:0] HZ_FW_NONE = 2'b00;
  localparam logic [1:0] HZ_FW_WE   = 2'b01;
  localparam logic [1:0] HZ_FW_ME   = 2'b10;

  localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW:0] TO_L = (WCW+1)'(MEM_TIMEOUT);

  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_ERR} mem_state_e;

  mem_state_e       state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [WCW:0]     stall_no;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d, cnt_mw_q, cnt_mw_d, cnt_fl_q, cnt_fl_d;
  logic             mem_stall, mem_drop, to_hit;
  logic             rs_dep, rt_dep, lu_hit, nf_hit, raw_hit;
  logic             raw_act, branch_act;

  function automatic logic [1:0] fw_sel(input logic [REG_W-1:0] src,
                                        input logic [REG_W-1:0] dst_m, input logic wr_m,
                                        input logic [REG_W-1:0] dst_w, input logic wr_w);
    logic [1:0] sel;
    sel = HZ_FW_NONE;
    if (FORWARD_EN != 0 && src != '0) begin
      if (wr_m && src == dst_m)      sel = HZ_FW_ME;
      else if (wr_w && src == dst_w) sel = HZ_FW_WE;
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction

  assign dmReq         = cw_memToReg_M | cw_memWrite_M;
  assign hz_forwardA_E = fw_sel(instrRs_E, writeReg_M, cw_regWrite_M, writeReg_W, cw_regWrite_W);
  assign hz_forwardB_E = fw_sel(instrRt_E, writeReg_M, cw_regWrite_M, writeReg_W, cw_regWrite_W);

  // W needs no check: the register file writes on the falling edge.
  assign rs_dep  = (instrRs_D != '0) && ((cw_regWrite_E && instrRs_D == writeReg_E) ||
                                         (cw_regWrite_M && instrRs_D == writeReg_M));
  assign rt_dep  = (instrRt_D != '0) && ((cw_regWrite_E && instrRt_D == writeReg_E) ||
                                         (cw_regWrite_M && instrRt_D == writeReg_M));
  assign lu_hit  = (LOAD_STALL_EN != 0) && cw_memToReg_E && (writeReg_E != '0) &&
                   (instrRs_D == writeReg_E || instrRt_D == writeReg_E);
  assign nf_hit  = (FORWARD_EN == 0) && (rs_dep || rt_dep);
  assign raw_hit = lu_hit | nf_hit;

  // stall_no is the ordinal of the stall cycle being taken now; reaching the limit
  // hands the access to ERR so exactly MEM_TIMEOUT stall cycles precede the drop.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_stall  = 1'b0;
    mem_drop   = 1'b0;
    stall_no   = {1'b0, wait_cnt_q} + (WCW+1)'(1);
    to_hit     = (MEM_TIMEOUT != 0) && (stall_no == TO_L);
    case (state_q)
      MEM_IDLE, MEM_WAIT: begin
        if (dmReq && !dmAck) begin
          mem_stall = 1'b1;
          if (to_hit) begin
            state_d    = MEM_ERR;
            wait_cnt_d = '0;
          end else begin
            state_d    = MEM_WAIT;
            wait_cnt_d = stall_no[WCW] ? wait_cnt_q : stall_no[WCW-1:0];
          end
        end else begin
          state_d    = MEM_IDLE;
          wait_cnt_d = '0;
        end
      end
      MEM_ERR: begin
        mem_drop   = 1'b1;
        state_d    = MEM_IDLE;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = MEM_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    hz_stall_F   = 1'b0;
    hz_stall_D   = 1'b0;
    hz_stall_E   = 1'b0;
    hz_stall_M   = 1'b0;
    hz_flush_n_D = 1'b1;
    hz_flush_n_E = 1'b1;
    hz_flush_n_M = 1'b1;
    hz_flush_n_W = 1'b1;
    raw_act      = 1'b0;
    branch_act   = 1'b0;
    if (mem_stall) begin
      hz_stall_F   = 1'b1;
      hz_stall_D   = 1'b1;
      hz_stall_E   = 1'b1;
      hz_stall_M   = 1'b1;
      hz_flush_n_W = 1'b0;
    end else begin
      hz_flush_n_W = !mem_drop;
      if (cw_pcSrc_M) begin
        branch_act   = 1'b1;
        hz_flush_n_D = 1'b0;
        hz_flush_n_E = 1'b0;
        hz_flush_n_M = 1'b0;
      end else if (raw_hit) begin
        raw_act      = 1'b1;
        hz_stall_F   = 1'b1;
        hz_stall_D   = 1'b1;
        hz_flush_n_E = 1'b0;
      end
    end
  end

  assign mem_err_d = mem_err_q | (state_d == MEM_ERR);
  assign cnt_lu_d  = sat_inc(cnt_lu_q, raw_act);
  assign cnt_mw_d  = sat_inc(cnt_mw_q, mem_stall);
  assign cnt_fl_d  = sat_inc(cnt_fl_q, branch_act);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MEM_IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
      cnt_lu_q   <= '0;
      cnt_mw_q   <= '0;
      cnt_fl_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      cnt_lu_q   <= cnt_lu_d;
      cnt_mw_q   <= cnt_mw_d;
      cnt_fl_q   <= cnt_fl_d;
    end
  end

  assign hz_memErr   = mem_err_q;
  assign cnt_luStall = cnt_lu_q;
  assign cnt_memWait = cnt_mw_q;
  assign cnt_flush   = cnt_fl_q;

endmodule

// File: tb/tb_sm_hazard_ctrl.sv
// Bench for sm_hazard_ctrl: instance a (forwarding on, timeout 4, 32-bit counters) and
// instance b (forwarding off, no timeout, 3-bit counters) share directed stimulus.
module tb_sm_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic       rw_e, rw_m, rw_w, m2r_e, m2r_m, mw_m, pcsrc, ack;

  logic [1:0]  fa_a, fb_a, fa_b, fb_b;
  logic        req_a, sf_a, sd_a, se_a, sm_a, fnd_a, fne_a, fnm_a, fnw_a, err_a;
  logic        req_b, sf_b, sd_b, se_b, sm_b, fnd_b, fne_b, fnm_b, fnw_b, err_b;
  logic [31:0] lu_a, mwc_a, fl_a;
  logic [2:0]  lu_b, mwc_b, fl_b;

  sm_hazard_ctrl #(.REG_W(5), .FORWARD_EN(1), .LOAD_STALL_EN(1), .MEM_TIMEOUT(4), .CNT_W(32)) u_a (
    .clk(clk), .rst_n(rst_n), .instrRs_D(rs_d), .instrRt_D(rt_d), .instrRs_E(rs_e), .instrRt_E(rt_e),
    .writeReg_E(wr_e), .writeReg_M(wr_m), .writeReg_W(wr_w), .cw_regWrite_E(rw_e), .cw_regWrite_M(rw_m),
    .cw_regWrite_W(rw_w), .cw_memToReg_E(m2r_e), .cw_memToReg_M(m2r_m), .cw_memWrite_M(mw_m),
    .cw_pcSrc_M(pcsrc), .dmAck(ack), .dmReq(req_a), .hz_forwardA_E(fa_a), .hz_forwardB_E(fb_a),
    .hz_stall_F(sf_a), .hz_stall_D(sd_a), .hz_stall_E(se_a), .hz_stall_M(sm_a),
    .hz_flush_n_D(fnd_a), .hz_flush_n_E(fne_a), .hz_flush_n_M(fnm_a), .hz_flush_n_W(fnw_a),
    .hz_memErr(err_a), .cnt_luStall(lu_a), .cnt_memWait(mwc_a), .cnt_flush(fl_a));

  sm_hazard_ctrl #(.REG_W(5), .FORWARD_EN(0), .LOAD_STALL_EN(1), .MEM_TIMEOUT(0), .CNT_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .instrRs_D(rs_d), .instrRt_D(rt_d), .instrRs_E(rs_e), .instrRt_E(rt_e),
    .writeReg_E(wr_e), .writeReg_M(wr_m), .writeReg_W(wr_w), .cw_regWrite_E(rw_e), .cw_regWrite_M(rw_m),
    .cw_regWrite_W(rw_w), .cw_memToReg_E(m2r_e), .cw_memToReg_M(m2r_m), .cw_memWrite_M(mw_m),
    .cw_pcSrc_M(pcsrc), .dmAck(ack), .dmReq(req_b), .hz_forwardA_E(fa_b), .hz_forwardB_E(fb_b),
    .hz_stall_F(sf_b), .hz_stall_D(sd_b), .hz_stall_E(se_b), .hz_stall_M(sm_b),
    .hz_flush_n_D(fnd_b), .hz_flush_n_E(fne_b), .hz_flush_n_M(fnm_b), .hz_flush_n_W(fnw_b),
    .hz_memErr(err_b), .cnt_luStall(lu_b), .cnt_memWait(mwc_b), .cnt_flush(fl_b));

  logic [13:0] ctl_a, ctl_b;
  assign ctl_a = {fa_a, fb_a, sf_a, sd_a, se_a, sm_a, fnd_a, fne_a, fnm_a, fnw_a, err_a, req_a};
  assign ctl_b = {fa_b, fb_b, sf_b, sd_b, se_b, sm_b, fnd_b, fne_b, fnm_b, fnw_b, err_b, req_b};

  int nchk = 0;
  int nerr = 0;
  bit run  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: k=0 is instance a, k=1 is instance b.
  int     waits   [2];
  bit     err_cyc [2];
  bit     memerr  [2];
  longint cnt_lu  [2];
  longint cnt_mw  [2];
  longint cnt_fl  [2];

  function automatic int to_of(int k);
    return (k == 0) ? 4 : 0;
  endfunction

  function automatic longint satv(int k, longint v);
    longint mx = (k == 0) ? 64'hFFFF_FFFF : 64'd7;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [1:0] fw_exp(int k, logic [4:0] src);
    if (k != 0 || src == 0) return 2'b00;
    if (rw_m && src == wr_m) return 2'b10;
    if (rw_w && src == wr_w) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit dep(logic [4:0] r);
    return (r != 0) && ((rw_e && r == wr_e) || (rw_m && r == wr_m));
  endfunction

  function automatic bit raw_need(int k);
    bit lu = m2r_e && (wr_e != 0) && (rs_d == wr_e || rt_d == wr_e);
    bit nf = (k == 1) && (dep(rs_d) || dep(rt_d));
    return lu || nf;
  endfunction

  function automatic bit mstall(int k);
    return !err_cyc[k] && (m2r_m || mw_m) && !ack;
  endfunction

  function automatic bit br_now(int k);
    return !mstall(k) && pcsrc;
  endfunction

  function automatic bit raw_now(int k);
    return !mstall(k) && !pcsrc && raw_need(k);
  endfunction

  function automatic bit next_err(int k);
    return mstall(k) && (to_of(k) != 0) && (waits[k] + 1 == to_of(k));
  endfunction

  function automatic int next_waits(int k);
    return (!mstall(k) || next_err(k)) ? 0 : waits[k] + 1;
  endfunction

  function automatic logic [13:0] exp_ctl(int k);
    logic ms, br, rw;
    ms = mstall(k);
    br = br_now(k);
    rw = raw_now(k);
    return {fw_exp(k, rs_e), fw_exp(k, rt_e), ms | rw, ms | rw, ms, ms,
            !br, !(br | rw), !br, !(ms | err_cyc[k]), memerr[k], m2r_m | mw_m};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        waits[k]   <= 0;
        err_cyc[k] <= 1'b0;
        memerr[k]  <= 1'b0;
        cnt_lu[k]  <= 0;
        cnt_mw[k]  <= 0;
        cnt_fl[k]  <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        waits[k]   <= next_waits(k);
        err_cyc[k] <= next_err(k);
        memerr[k]  <= memerr[k] | next_err(k);
        cnt_lu[k]  <= satv(k, cnt_lu[k] + (raw_now(k) ? 1 : 0));
        cnt_mw[k]  <= satv(k, cnt_mw[k] + (mstall(k) ? 1 : 0));
        cnt_fl[k]  <= satv(k, cnt_fl[k] + (br_now(k) ? 1 : 0));
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("ctl_a", 32'(ctl_a), 32'(exp_ctl(0)));
      chk("ctl_b", 32'(ctl_b), 32'(exp_ctl(1)));
      chk("cnt_lu_a", lu_a, 32'(cnt_lu[0]));
      chk("cnt_mw_a", mwc_a, 32'(cnt_mw[0]));
      chk("cnt_fl_a", fl_a, 32'(cnt_fl[0]));
      chk("cnt_lu_b", 32'(lu_b), 32'(cnt_lu[1]));
      chk("cnt_mw_b", 32'(mwc_b), 32'(cnt_mw[1]));
      chk("cnt_fl_b", 32'(fl_b), 32'(cnt_fl[1]));
    end
  end

  task automatic clr();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; wr_e = 0; wr_m = 0; wr_w = 0;
    rw_e = 0; rw_m = 0; rw_w = 0; m2r_e = 0; m2r_m = 0; mw_m = 0; pcsrc = 0; ack = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    run = 1'b1;
    #2;
    chk("rst_stall_F", 32'(sf_a), 32'd0);
    chk("rst_flush_n_W", 32'(fnw_a), 32'd1);
    chk("rst_memErr", 32'(err_a), 32'd0);
    chk("rst_cnt_lu", lu_a, 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // forwarding priority M over W, and register 0
    rs_e = 3; wr_m = 3; rw_m = 1; wr_w = 3; rw_w = 1;
    #2 chk("fwA_me", 32'(fa_a), 32'd2); chk("fwA_off", 32'(fa_b), 32'd0);
    tick();
    rw_m = 0; rt_e = 3;
    #2 chk("fwA_we", 32'(fa_a), 32'd1); chk("fwB_we", 32'(fb_a), 32'd1);
    tick();
    rs_e = 0;
    #2 chk("fwA_r0", 32'(fa_a), 32'd0);
    tick(); clr();

    // load-use: one stall cycle, then none for destination 0
    m2r_e = 1; rw_e = 1; wr_e = 5; rt_d = 5;
    #2 chk("lu_stall_F", 32'(sf_a), 32'd1); chk("lu_flush_n_E", 32'(fne_a), 32'd0);
    chk("lu_stall_M", 32'(sm_a), 32'd0);
    tick(); clr();
    #2 chk("lu_cnt", lu_a, 32'd1); chk("lu_release", 32'(sf_a), 32'd0);
    tick();
    m2r_e = 1; rw_e = 1; wr_e = 0; rt_d = 0;
    #2 chk("lu_r0_a", 32'(sf_a), 32'd0); chk("lu_r0_b", 32'(sf_b), 32'd0);
    tick(); clr();

    // branch beats load-use
    pcsrc = 1; m2r_e = 1; rw_e = 1; wr_e = 5; rt_d = 5;
    #2 chk("br_flush_n_D", 32'(fnd_a), 32'd0); chk("br_flush_n_M", 32'(fnm_a), 32'd0);
    chk("br_no_stall", 32'(sf_a), 32'd0);
    tick(); clr();
    #2 chk("br_cnt_flush", fl_a, 32'd1); chk("br_cnt_lu", lu_a, 32'd1);
    tick();

    // 3-cycle memory wait, then zero-wait access
    m2r_m = 1; ack = 0;
    repeat (3) begin
      #2 chk("mw_stall_M", 32'(sm_a), 32'd1); chk("mw_flush_n_W", 32'(fnw_a), 32'd0);
      tick();
    end
    ack = 1;
    #2 chk("mw_ack_stall_M", 32'(sm_a), 32'd0); chk("mw_ack_flush_n_W", 32'(fnw_a), 32'd1);
    tick(); clr();
    #2 chk("mw_cnt_a", mwc_a, 32'd3); chk("mw_cnt_b", 32'(mwc_b), 32'd3);
    tick();
    m2r_m = 1; ack = 1;
    #2 chk("zw_stall_M", 32'(sm_a), 32'd0); chk("zw_dmReq", 32'(req_a), 32'd1);
    tick(); clr();

    // timeout on a: 4 stalls then ERR; b keeps waiting
    mw_m = 1; ack = 0;
    repeat (4) begin
      #2 chk("to_stall_M", 32'(sm_a), 32'd1);
      tick();
    end
    #2 chk("err_stall_M", 32'(sm_a), 32'd0); chk("err_flush_n_W", 32'(fnw_a), 32'd0);
    chk("err_memErr", 32'(err_a), 32'd1); chk("err_b_stall", 32'(sm_b), 32'd1);
    tick(); clr(); tick();
    #2 chk("memErr_sticky", 32'(err_a), 32'd1); chk("memErr_b", 32'(err_b), 32'd0);
    chk("to_cnt_mw_a", mwc_a, 32'd7); chk("sat_cnt_mw_b", 32'(mwc_b), 32'd7);
    tick();

    // forwarding off: M-stage dependency stalls b only
    rs_d = 7; rs_e = 7; wr_m = 7; rw_m = 1;
    #2 chk("nf_stall_b", 32'(sf_b), 32'd1); chk("nf_flush_n_E_b", 32'(fne_b), 32'd0);
    chk("nf_fwA_b", 32'(fa_b), 32'd0); chk("nf_stall_a", 32'(sf_a), 32'd0);
    chk("nf_fwA_a", 32'(fa_a), 32'd2);
    tick(); clr();
    #2 chk("nf_cnt_lu_b", 32'(lu_b), 32'd2);
    tick();

    // reset in the middle of a wait
    m2r_m = 1; ack = 0;
    tick(); tick();
    #1 chk("pre_rst_stall_M", 32'(sm_a), 32'd1);
    #1 rst_n = 1'b0; clr();
    #1 chk("rst_wait_stall_M", 32'(sm_a), 32'd0); chk("rst_memErr_a", 32'(err_a), 32'd0);
    chk("rst_cnt_mw", mwc_a, 32'd0); chk("rst_cnt_fl", fl_a, 32'd0); chk("rst_cnt_lu_b", 32'(lu_b), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // fresh timeout after reset, checked by the model
    m2r_m = 1; ack = 0;
    repeat (5) tick();
    clr();
    repeat (3) tick();

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
